// File: rtl/frac_delay_reader_pkg.sv
// Shared constants for the fractional delay reader.
// Holds the state encoding and delay field widths.
package frac_delay_reader_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int FRAC_W = 3;
    localparam int DELAY_W = ADDR_W + FRAC_W;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] S_CLEAR = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_RD_BASE = 3'd3;
    localparam logic [2:0] S_RD_TGT = 3'd4;
    localparam logic [2:0] S_START = 3'd5;
    localparam logic [2:0] S_WAIT = 3'd6;
    localparam logic [2:0] S_OUT = 3'd7;

endpackage

// File: rtl/frac_delay_reader_if.sv
// Sample, interpolator and output handshake bundle.
// The slave side is the delay reader itself.
interface frac_delay_reader_if #(
    parameter int data_width = 16,
    parameter int addr_width = 10,
    parameter int interp_bits = 3
);

    logic in_valid;
    logic in_ready;
    logic signed [data_width-1:0] in_sample;
    logic [addr_width+interp_bits-1:0] delay;

    logic interp_start;
    logic signed [data_width-1:0] interp_base;
    logic signed [data_width-1:0] interp_target;
    logic [interp_bits-1:0] interp_frac;
    logic interp_valid;
    logic signed [data_width-1:0] interp_result;

    logic out_valid;
    logic signed [data_width-1:0] out_sample;

    modport slave (
        input in_valid,
        input in_sample,
        input delay,
        input interp_valid,
        input interp_result,
        output in_ready,
        output interp_start,
        output interp_base,
        output interp_target,
        output interp_frac,
        output out_valid,
        output out_sample
    );

    modport master (
        output in_valid,
        output in_sample,
        output delay,
        output interp_valid,
        output interp_result,
        input in_ready,
        input interp_start,
        input interp_base,
        input interp_target,
        input interp_frac,
        input out_valid,
        input out_sample
    );

endinterface

// File: rtl/frac_delay_reader_delay_ram.sv
// Single-port delay line storage, synchronous read.
// Read data appears one cycle after the address is presented.
module frac_delay_reader_delay_ram #(
    parameter int data_width = 16,
    parameter int addr_width = 10
) (
    input logic clk,
    input logic we,
    input logic [addr_width-1:0] addr,
    input logic [data_width-1:0] wdata,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem [0:(1<<addr_width)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/frac_delay_reader.sv
// Circular delay line that fetches taps D and D+1 for the
// interpolator and returns its result as the delayed sample.
module frac_delay_reader
    import frac_delay_reader_pkg::*;
#(
    parameter int data_width = DATA_W,
    parameter int addr_width = ADDR_W,
    parameter int interp_bits = FRAC_W
) (
    input logic clk,
    input logic reset_n,
    frac_delay_reader_if.slave bus
);

    localparam logic [addr_width-1:0] A_ONE = {{(addr_width-1){1'b0}}, 1'b1};
    localparam logic [addr_width-1:0] D_MAX = {{(addr_width-1){1'b1}}, 1'b0};

    logic [2:0] state;
    logic [addr_width-1:0] clr_idx;
    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] base_addr;
    logic [addr_width-1:0] tgt_addr;
    logic [addr_width-1:0] d_int_q;
    logic [interp_bits-1:0] frac_q;
    logic [data_width-1:0] smp_q;

    logic [data_width-1:0] base_q;
    logic [data_width-1:0] target_q;
    logic [interp_bits-1:0] frac_out_q;
    logic [data_width-1:0] out_q;

    logic [addr_width-1:0] d_in;
    logic [addr_width-1:0] d_clamp;

    logic ram_we;
    logic [addr_width-1:0] ram_addr;
    logic [data_width-1:0] ram_wdata;
    logic [data_width-1:0] ram_rdata;

    assign d_in = bus.delay[addr_width+interp_bits-1:interp_bits];
    // Tap D+1 must stay behind the write pointer, so D tops out at depth-2.
    assign d_clamp = (&d_in) ? D_MAX : d_in;

    frac_delay_reader_delay_ram #(
        .data_width(data_width),
        .addr_width(addr_width)
    ) u_delay_ram (
        .clk(clk),
        .we(ram_we),
        .addr(ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_comb begin
        ram_we = 1'b0;
        ram_addr = clr_idx;
        ram_wdata = '0;
        unique case (state)
            S_CLEAR: ram_we = 1'b1;
            S_WRITE: begin
                ram_we = 1'b1;
                ram_addr = wr_ptr;
                ram_wdata = smp_q;
            end
            S_RD_BASE: ram_addr = base_addr;
            S_RD_TGT: ram_addr = tgt_addr;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_CLEAR;
            clr_idx <= '0;
            wr_ptr <= '0;
            base_addr <= '0;
            tgt_addr <= '0;
            d_int_q <= '0;
            frac_q <= '0;
            smp_q <= '0;
            base_q <= '0;
            target_q <= '0;
            frac_out_q <= '0;
            out_q <= '0;
        end else begin
            unique case (state)
                S_CLEAR: begin
                    clr_idx <= clr_idx + A_ONE;
                    if (&clr_idx) begin
                        state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (bus.in_valid) begin
                        smp_q <= bus.in_sample;
                        d_int_q <= d_clamp;
                        frac_q <= bus.delay[interp_bits-1:0];
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    base_addr <= wr_ptr - d_int_q;
                    tgt_addr <= wr_ptr - d_int_q - A_ONE;
                    state <= S_RD_BASE;
                end
                S_RD_BASE: state <= S_RD_TGT;
                S_RD_TGT: begin
                    base_q <= ram_rdata;
                    frac_out_q <= frac_q;
                    state <= S_START;
                end
                S_START: begin
                    target_q <= ram_rdata;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.interp_valid) begin
                        out_q <= bus.interp_result;
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    wr_ptr <= wr_ptr + A_ONE;
                    state <= S_IDLE;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    // Target is forwarded straight from the RAM during the start pulse.
    assign bus.interp_target = (state == S_START) ? ram_rdata : target_q;
    assign bus.in_ready = (state == S_IDLE);
    assign bus.interp_start = (state == S_START);
    assign bus.interp_base = base_q;
    assign bus.interp_frac = frac_out_q;
    assign bus.out_valid = (state == S_OUT);
    assign bus.out_sample = out_q;

endmodule

// File: tb/tb_frac_delay_reader.sv
// Directed bench for frac_delay_reader with a fixed-latency
// interpolator model that returns the base tap.
module tb_frac_delay_reader;

    logic clk;
    logic reset_n;
    int cmps;
    int errs;

    frac_delay_reader_if bus ();

    frac_delay_reader dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        cmps++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_wait(input string tag);
        int n;
        int bad;
        n = 0;
        bad = 0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            @(posedge clk);
            n++;
            #1;
            bus.interp_valid = 1'b0;
            if (bus.interp_start || bus.out_valid || bus.interp_base != 0 ||
                bus.interp_target != 0 || bus.interp_frac != 0)
                bad++;
            if (bus.in_ready) break;
        end
        chk({tag, "_len"}, n, 1024);
        chk({tag, "_quiet"}, bad, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        clear_wait(tag);
    endtask

    task automatic xact(input logic signed [15:0] s, input logic [12:0] d,
                        output logic signed [15:0] b,
                        output logic signed [15:0] t,
                        output logic [2:0] f,
                        output logic signed [15:0] o);
        int sn;
        int on;
        int ns;
        int no;
        bit ok;
        sn = -1;
        on = -1;
        ns = 0;
        no = 0;
        ok = 1'b0;
        b = '0;
        t = '0;
        f = '0;
        o = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ready_wait", ok, 1);
        bus.in_valid = 1'b1;
        bus.in_sample = s;
        bus.delay = d;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("ready_drop", bus.in_ready, 0);
        for (int n = 2; n <= 11; n++) begin
            @(negedge clk);
            if (bus.interp_start) begin
                ns++;
                sn = n;
                b = bus.interp_base;
                t = bus.interp_target;
                f = bus.interp_frac;
            end
            if (bus.out_valid) begin
                no++;
                on = n;
                o = bus.out_sample;
            end
            if (n == 7) begin
                bus.interp_valid = 1'b1;
                bus.interp_result = b;
            end
            if (n == 8) bus.interp_valid = 1'b0;
        end
        chk("start_cyc", sn, 4);
        chk("start_cnt", ns, 1);
        chk("out_cyc", on, 8);
        chk("out_cnt", no, 1);
    endtask

    initial begin
        logic signed [15:0] b;
        logic signed [15:0] t;
        logic [2:0] f;
        logic signed [15:0] o;
        logic signed [15:0] s3 [3];
        logic signed [15:0] eb;
        logic signed [15:0] et;

        cmps = 0;
        errs = 0;
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sample = '0;
        bus.delay = '0;
        bus.interp_valid = 1'b0;
        bus.interp_result = '0;

        repeat (2) @(negedge clk);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_start", bus.interp_start, 0);
        chk("rst_outv", bus.out_valid, 0);
        chk("rst_out", bus.out_sample, 0);
        clear_wait("clr0");

        s3[0] = 16'sd100;
        s3[1] = -16'sd200;
        s3[2] = 16'sd300;
        for (int i = 0; i < 3; i++) begin
            xact(s3[i], 13'd0, b, t, f, o);
            chk("d0_base", b, s3[i]);
            chk("d0_out", o, s3[i]);
            chk("d0_frac", f, 0);
        end
        chk("d0_tgt", t, -200);

        do_reset("clr1");
        for (int i = 0; i < 8; i++) begin
            xact((i == 0) ? 16'sd1000 : 16'sd0, {10'd5, 3'd0}, b, t, f, o);
            chk("imp5_out", o, (i == 5) ? 1000 : 0);
            chk("imp5_tgt", t, (i == 6) ? 1000 : 0);
        end

        do_reset("clr2");
        for (int i = 0; i < 4; i++) begin
            xact((i == 0) ? 16'sd1000 : 16'sd0, {10'd2, 3'd4}, b, t, f, o);
            if (i == 2) begin
                chk("fr_b2", b, 1000);
                chk("fr_t2", t, 0);
                chk("fr_f2", f, 4);
            end
            if (i == 3) begin
                chk("fr_b3", b, 0);
                chk("fr_t3", t, 1000);
                chk("fr_f3", f, 4);
            end
        end

        do_reset("clr3");
        for (int k = 0; k < 1030; k++) begin
            xact(16'(k + 1), {10'd10, 3'd0}, b, t, f, o);
            if (k == 9 || k == 10 || k == 1023 || k == 1029) begin
                eb = (k >= 10) ? 16'(k - 9) : 16'sd0;
                et = (k >= 11) ? 16'(k - 10) : 16'sd0;
                chk("wrap_base", b, eb);
                chk("wrap_tgt", t, et);
            end
        end
        xact(16'sd1031, {10'd1023, 3'd5}, b, t, f, o);
        chk("clamp_base", b, 9);
        chk("clamp_tgt", t, 8);
        chk("clamp_frac", f, 5);

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        bus.in_valid = 1'b1;
        bus.in_sample = 16'sd555;
        bus.delay = {10'd3, 3'd2};
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_ready", bus.in_ready, 0);
        chk("mid_start", bus.interp_start, 0);
        chk("mid_base", bus.interp_base, 0);
        chk("mid_tgt", bus.interp_target, 0);
        chk("mid_frac", bus.interp_frac, 0);
        chk("mid_outv", bus.out_valid, 0);
        chk("mid_out", bus.out_sample, 0);
        bus.interp_valid = 1'b1;
        bus.interp_result = 16'sd77;
        clear_wait("clr4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule

// File: doc/frac_delay_reader.md
Name: frac_delay_reader

Overview:
- Circular-buffer delay line feeding the sequential interpolator. It stores incoming audio samples and fetches the two neighbouring taps (integer delay D and D+1) for a fixed-point delay request.
- It hands base, target and frac to the interpolator over a start/valid handshake, then registers and emits the interpolated sample.
- Sits between the per-sample effect datapath (upstream) and sequential_interp (downstream and back).

Parameters:
- data_width, 16, sample width (signed).
- addr_width, 10, buffer address width; depth = 2^addr_width.
- interp_bits, 3, fractional delay bits; must match the interpolator.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample strobe.
- in_ready  out  1  block can accept a sample.
- in_sample  in  data_width  signed input sample.
- delay  in  addr_width+interp_bits  unsigned delay: upper addr_width bits integer, lower interp_bits fraction.
- interp_start  out  1  one-cycle start pulse to interpolator.
- interp_base  out  data_width  sample at delay D.
- interp_target  out  data_width  sample at delay D+1.
- interp_frac  out  interp_bits  fractional delay.
- interp_valid  in  1  interpolator result valid.
- interp_result  in  data_width  interpolated value.
- out_valid  out  1  one-cycle output strobe.
- out_sample  out  data_width  delayed sample.

Behaviour:
- Reset (async, reset_n low): all outputs 0; wr_ptr=0; state=CLEAR; clear index=0. Memory is not reset directly.
- CLEAR: writes 0 to one address per cycle, 0..depth-1 (depth cycles), then goes to IDLE. in_ready=0 throughout.
- IDLE: in_ready=1. When in_valid is high, latch in_sample and delay, then go to WRITE. in_ready drops the next cycle and stays low until IDLE is re-entered.
- Integer delay clamp: D = min(delay_int, depth-2). Fraction passes through unchanged.
- WRITE: mem[wr_ptr] <= sample; base_addr = wr_ptr - D; tgt_addr = base_addr - 1. All address arithmetic is modulo depth (wrap).
- RD_BASE: issue synchronous read of base_addr (1-cycle read latency).
- RD_TGT: capture base data into interp_base; issue read of tgt_addr.
- START: capture target data into interp_target; interp_frac = latched fraction; interp_start=1 for exactly this cycle.
- WAIT: hold interp_base, interp_target and interp_frac stable. On interp_valid, register interp_result into out_sample and go to OUT.
- OUT: out_valid=1 for one cycle; wr_ptr <= wr_ptr+1 (wraps); go to IDLE.
- Latency: with handshake at cycle 0, interp_start is at cycle 4. interp_valid at cycle 4+L gives out_valid at cycle 5+L.
- D=0: base is the sample just written (write completes before the read is issued).
- interp_valid outside WAIT is ignored.
- in_valid outside IDLE is ignored; no queueing.
- out_sample holds its value between strobes.
- reset_n asserted mid-operation (any state): immediate return to reset values and re-run CLEAR. No out_valid is produced for the aborted sample.

Decomposition:
- Shared package holds the state encoding (CLEAR, IDLE, WRITE, RD_BASE, RD_TGT, START, WAIT, OUT) and the delay field-split helper constants (integer/fraction widths, DEPTH).
- One sub-module: delay_ram, a single-port synchronous-read RAM with 1-cycle read latency. Single port is sufficient because write and read cycles are disjoint.

Test Plan:
- Reset then idle -> in_ready=0 for exactly 1024 cycles after reset_n rises, then 1. All interp_* outputs and out_valid stay 0 during CLEAR.
- Delay 0.0 (delay=0), samples 100, -200, 300 with a bench interp model returning base at fixed L=3 -> interp_base = 100, -200, 300. Each out_valid is 8 cycles after its accept.
- Impulse 1000 then zeros, delay int 5 frac 0 -> out_sample nonzero (1000) only on the 6th output (index 5). interp_target=1000 only on output index 6.
- Impulse 1000, delay int 2 frac 4 (0.5) -> output index 2 has base=1000, target=0, frac=4. Index 3 has base=0, target=1000, frac=4.
- Clamp and wrap: delay int 1023 is clamped to 1022. After 1030 accepted writes with delay int 10, base equals the sample written 10 accepts earlier (wr_ptr wrapped).
- Reset mid-WAIT: pulse reset_n low while waiting and then drive interp_valid -> no out_valid, all outputs 0, CLEAR restarts (in_ready low for 1024 cycles).
